// File: rtl/auth_pkg.sv
// Shared definitions for the challenge issuer: session states, challenge
// width and the LFSR feedback function used to draw fresh challenges.
package auth_pkg;

  localparam int CHAL_W = 4;

  // Feedback taps for x^4 + x^3 + 1 (bits 3 and 2 of the state).
  localparam logic [CHAL_W-1:0] LFSR_TAPS = 4'b1100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RESP = 3'd2,
    SETTLE    = 3'd3,
    EVAL      = 3'd4,
    LOCKOUT   = 3'd5
  } state_t;

  // Shift left, feeding back the XOR of the tapped bits into bit 0.
  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] s);
    return {s[CHAL_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/auth_lfsr4.sv
// 4-bit maximal-length LFSR. It holds its state until adv_i is raised and
// exposes both the current state and the value it will take next.
module auth_lfsr4
  import auth_pkg::*;
#(
  parameter logic [CHAL_W-1:0] SEED = 4'b1011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv_i,
  output logic [CHAL_W-1:0] state_o,
  output logic [CHAL_W-1:0] next_o
);

  // An all-zero state would lock the LFSR up, so a zero seed becomes 1.
  localparam logic [CHAL_W-1:0] SEED_EFF = (SEED == '0) ? CHAL_W'(1) : SEED;

  logic [CHAL_W-1:0] lfsr_q;

  assign next_o  = lfsr_next(lfsr_q);
  assign state_o = lfsr_q;

  // Load the seed on reset; otherwise step only when asked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= SEED_EFF;
    end else if (adv_i) begin
      lfsr_q <= next_o;
    end
  end

endmodule

// File: rtl/challenge_issuer.sv
// Session controller in front of the challenge/response authenticator:
// issues a fresh challenge, captures the client's response, samples the
// authenticator verdict and enforces timeout and failure lockout.
module challenge_issuer
  import auth_pkg::*;
#(
  parameter logic [CHAL_W-1:0] SEED           = 4'b1011,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter int                MAX_FAILS      = 3,
  parameter int                LOCKOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [CHAL_W-1:0] response_in,
  input  logic              auth_ok,
  output logic [CHAL_W-1:0] challenge,
  output logic              challenge_valid,
  output logic [CHAL_W-1:0] response,
  output logic              busy,
  output logic              session_ok,
  output logic              session_fail,
  output logic              timeout,
  output logic              locked,
  output logic [1:0]        fail_count
);

  state_t            state_q, state_d;
  logic [CHAL_W-1:0] challenge_q, challenge_d;
  logic [CHAL_W-1:0] response_q, response_d;
  logic [7:0]        timer_q, timer_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic [1:0]        fail_count_q, fail_count_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic              lfsr_adv;
  logic [CHAL_W-1:0] lfsr_state;
  logic [CHAL_W-1:0] lfsr_nxt;
  logic              fail_event;
  logic [1:0]        fail_inc;

  auth_lfsr4 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_state),
    .next_o  (lfsr_nxt)
  );

  // Failure count saturates at 3 so it can never wrap back to zero.
  assign fail_inc = (fail_count_q == 2'd3) ? 2'd3 : fail_count_q + 2'd1;

  // Next-state logic: sequence the session and decide pass/fail/lockout.
  always_comb begin
    state_d      = state_q;
    challenge_d  = challenge_q;
    response_d   = response_q;
    timer_d      = timer_q;
    lock_cnt_d   = lock_cnt_q;
    fail_count_d = fail_count_q;
    ok_d         = 1'b0;
    fail_d       = 1'b0;
    timeout_d    = 1'b0;
    lfsr_adv     = 1'b0;
    fail_event   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        lfsr_adv    = 1'b1;
        challenge_d = lfsr_nxt;
        timer_d     = 8'd0;
        state_d     = WAIT_RESP;
      end
      WAIT_RESP: begin
        timer_d = timer_q + 8'd1;
        // A response arriving on the expiry cycle takes priority.
        if (resp_valid) begin
          response_d = response_in;
          state_d    = SETTLE;
        end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
          fail_event = 1'b1;
          timeout_d  = 1'b1;
        end
      end
      SETTLE: begin
        // Inputs to the authenticator are stable; its verdict lands this edge.
        state_d = EVAL;
      end
      EVAL: begin
        if (auth_ok) begin
          ok_d         = 1'b1;
          fail_count_d = 2'd0;
          state_d      = IDLE;
        end else begin
          fail_event = 1'b1;
        end
      end
      LOCKOUT: begin
        lock_cnt_d = lock_cnt_q + 8'd1;
        if (lock_cnt_q == 8'(LOCKOUT_CYCLES - 1)) begin
          fail_count_d = 2'd0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail_event) begin
      fail_d       = 1'b1;
      fail_count_d = fail_inc;
      if (fail_inc == 2'(MAX_FAILS)) begin
        lock_cnt_d = 8'd0;
        state_d    = LOCKOUT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State register; reset abandons any session without emitting a pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      challenge_q  <= '0;
      response_q   <= '0;
      timer_q      <= 8'd0;
      lock_cnt_q   <= 8'd0;
      fail_count_q <= 2'd0;
      ok_q         <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      challenge_q  <= challenge_d;
      response_q   <= response_d;
      timer_q      <= timer_d;
      lock_cnt_q   <= lock_cnt_d;
      fail_count_q <= fail_count_d;
      ok_q         <= ok_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
    end
  end

  assign challenge       = challenge_q;
  assign response        = response_q;
  assign challenge_valid = (state_q == WAIT_RESP);
  assign busy            = (state_q != IDLE);
  assign locked          = (state_q == LOCKOUT);
  assign session_ok      = ok_q;
  assign session_fail    = fail_q;
  assign timeout         = timeout_q;
  assign fail_count      = fail_count_q;

endmodule
